alu_result_buf: RTL and testbench

ALU_RESULT_BUF -- requirements
Module: alu_result_buf

---
 rtl/alu_result_buf.sv | 145 ++++++++++++++
 tb/tb_alu_result_buf.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buf.sv
// Two-entry result buffer between the ALU and write-back, with trapped-overflow counting.
// Define ALU_EXC_CAPTURE_EN to capture the first trapped overflow into the exc_* outputs.
module alu_result_buf #(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_result,
  input  logic          in_zero,
  input  logic          in_overflow,
  input  logic          in_trap,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  input  logic          flush,
  output logic          out_valid,
  output logic [N-1:0]  out_result,
  output logic          out_zero,
  output logic [RW-1:0] out_rd,
  output logic          out_we,
  input  logic          out_ready,
  output logic [15:0]   ovf_cnt,
  output logic          exc_valid,
  output logic [N-1:0]  exc_result,
  output logic [RW-1:0] exc_rd,
  input  logic          exc_clr
);

  logic [N-1:0]  result_q [2];
  logic          zero_q   [2];
  logic [RW-1:0] rd_q     [2];
  logic          we_q     [2];

  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic [1:0] count_q, count_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  logic push, pop, trap_push;

  // in_ready depends only on registered occupancy (and rst), never on out_ready.
  assign in_ready  = !rst && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign trap_push = push && in_overflow && in_trap;
  assign ovf_cnt   = ovf_cnt_q;

  always_comb begin
    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ovf_cnt_d = ovf_cnt_q;
    if (flush) begin
      count_d = 2'd0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (push) wptr_d = ~wptr_q;
      if (pop)  rptr_d = ~rptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
    if (trap_push && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= 2'd0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      ovf_cnt_q   <= 16'd0;
      result_q[0] <= '0;
      result_q[1] <= '0;
      zero_q[0]   <= 1'b0;
      zero_q[1]   <= 1'b0;
      rd_q[0]     <= '0;
      rd_q[1]     <= '0;
      we_q[0]     <= 1'b0;
      we_q[1]     <= 1'b0;
    end else begin
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_cnt_q <= ovf_cnt_d;
      if (push) begin
        result_q[wptr_q] <= in_result;
        zero_q[wptr_q]   <= in_zero;
        rd_q[wptr_q]     <= in_rd;
        // A trapping overflow must never reach the register file.
        we_q[wptr_q]     <= in_we && !(in_overflow && in_trap);
      end
    end
  end

  always_comb begin
    out_result = '0;
    out_zero   = 1'b0;
    out_rd     = '0;
    out_we     = 1'b0;
    if (out_valid) begin
      out_result = result_q[rptr_q];
      out_zero   = zero_q[rptr_q];
      out_rd     = rd_q[rptr_q];
      out_we     = we_q[rptr_q];
    end
  end

`ifdef ALU_EXC_CAPTURE_EN
  logic          exc_valid_q;
  logic [N-1:0]  exc_result_q;
  logic [RW-1:0] exc_rd_q;

  // A clear in the same cycle as a new trap frees the slot for that new trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_valid_q  <= 1'b0;
      exc_result_q <= '0;
      exc_rd_q     <= '0;
    end else if (trap_push && (!exc_valid_q || exc_clr)) begin
      exc_valid_q  <= 1'b1;
      exc_result_q <= in_result;
      exc_rd_q     <= in_rd;
    end else if (exc_clr) begin
      exc_valid_q  <= 1'b0;
    end
  end

  assign exc_valid  = exc_valid_q;
  assign exc_result = exc_result_q;
  assign exc_rd     = exc_rd_q;
`else
  logic unused_exc_clr;
  assign unused_exc_clr = exc_clr;
  assign exc_valid      = 1'b0;
  assign exc_result     = '0;
  assign exc_rd         = '0;
`endif

endmodule

// File: tb/tb_alu_result_buf.sv
// Directed self-checking bench for alu_result_buf; expectations follow ALU_EXC_CAPTURE_EN.
module tb_alu_result_buf;

`ifdef ALU_EXC_CAPTURE_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic        in_zero, in_overflow, in_trap, in_we, flush;
  logic [4:0]  in_rd;
  logic        out_valid, out_zero, out_we, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [15:0] ovf_cnt;
  logic        exc_valid, exc_clr;
  logic [31:0] exc_result;
  logic [4:0]  exc_rd;

  int passCount  = 0;
  int checkCount = 0;
  logic [15:0] expOvf = 16'd0;
  logic [31:0] expExcResult;
  logic [4:0]  expExcRd;

  alu_result_buf #(.N(32), .RW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_overflow(in_overflow), .in_trap(in_trap),
    .in_rd(in_rd), .in_we(in_we), .flush(flush),
    .out_valid(out_valid), .out_result(out_result), .out_zero(out_zero),
    .out_rd(out_rd), .out_we(out_we), .out_ready(out_ready),
    .ovf_cnt(ovf_cnt), .exc_valid(exc_valid), .exc_result(exc_result),
    .exc_rd(exc_rd), .exc_clr(exc_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic z,
                       input logic ov, input logic tr, input logic [4:0] rd, input logic we);
    in_valid = v; in_result = r; in_zero = z; in_overflow = ov;
    in_trap = tr; in_rd = rd; in_we = we;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; exc_clr = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #2;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    else passCount++;
    checkCount++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    else passCount++;
    checkCount++;
    if (ovf_cnt !== 16'd0) $display("[TB] FAIL reset_ovf_cnt: got %0d expected 0", ovf_cnt);
    else passCount++;
    checkCount++;
    if (exc_valid !== 1'b0) $display("[TB] FAIL reset_exc_valid: got %b expected 0", exc_valid);
    else passCount++;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready);
    else passCount++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(1'b1, 32'd34, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkCount++;
    if (out_valid !== 1'b1 || out_result !== 32'd34 || out_rd !== 5'd3 || out_we !== 1'b1 || out_zero !== 1'b0)
      $display("[TB] FAIL basic_head: got v=%b r=%0d rd=%0d we=%b z=%b expected v=1 r=34 rd=3 we=1 z=0",
               out_valid, out_result, out_rd, out_we, out_zero);
    else passCount++;
    tick();
    checkCount++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0 || out_we !== 1'b0)
      $display("[TB] FAIL basic_empty_zeroed: got v=%b r=%0h rd=%0d we=%b expected all 0",
               out_valid, out_result, out_rd, out_we);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 32'd11, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
    tick();
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL b2b_ready_after_1: got %b expected 1", in_ready);
    else passCount++;
    drive(1'b1, 32'd22, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
    tick();
    checkCount++;
    if (in_ready !== 1'b0) $display("[TB] FAIL b2b_full_ready: got %b expected 0", in_ready);
    else passCount++;
    drive(1'b1, 32'd33, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
    tick();
    checkCount++;
    if (out_result !== 32'd11 || out_rd !== 5'd1 || in_ready !== 1'b0)
      $display("[TB] FAIL b2b_stall_hold: got r=%0d rd=%0d rdy=%b expected r=11 rd=1 rdy=0",
               out_result, out_rd, in_ready);
    else passCount++;
    // Third result is still presented; it is only accepted once a slot opens.
    out_ready = 1'b1;
    tick();
    checkCount++;
    if (out_result !== 32'd22 || in_ready !== 1'b1)
      $display("[TB] FAIL b2b_second: got r=%0d rdy=%b expected r=22 rdy=1", out_result, in_ready);
    else passCount++;
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkCount++;
    if (out_valid !== 1'b1 || out_result !== 32'd33 || out_rd !== 5'd4)
      $display("[TB] FAIL b2b_third: got v=%b r=%0d rd=%0d expected v=1 r=33 rd=4",
               out_valid, out_result, out_rd);
    else passCount++;
    tick();
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL b2b_drained: got %b expected 0", out_valid);
    else passCount++;
  endtask

  task automatic test_trap();
    out_ready = 1'b0;
    // 0x7ffffff1 + 0xf overflows into the sign bit.
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    expOvf = expOvf + 16'd1;
    expExcResult = EXC_ON ? 32'h8000_0000 : 32'd0;
    expExcRd     = EXC_ON ? 5'd7 : 5'd0;
    checkCount++;
    if (out_valid !== 1'b1 || out_result !== 32'h8000_0000 || out_we !== 1'b0)
      $display("[TB] FAIL trap_head: got v=%b r=%h we=%b expected v=1 r=80000000 we=0",
               out_valid, out_result, out_we);
    else passCount++;
    checkCount++;
    if (ovf_cnt !== expOvf) $display("[TB] FAIL trap_ovf_cnt: got %0d expected %0d", ovf_cnt, expOvf);
    else passCount++;
    checkCount++;
    if (exc_valid !== EXC_ON || exc_result !== expExcResult || exc_rd !== expExcRd)
      $display("[TB] FAIL trap_exc_capture: got v=%b r=%h rd=%0d expected v=%b r=%h rd=%0d",
               exc_valid, exc_result, exc_rd, EXC_ON, expExcResult, expExcRd);
    else passCount++;
    drive(1'b1, 32'h7FFF_FFF0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    expOvf = expOvf + 16'd1;
    checkCount++;
    if (ovf_cnt !== expOvf || exc_result !== expExcResult || exc_rd !== expExcRd)
      $display("[TB] FAIL trap_second_no_overwrite: got cnt=%0d r=%h rd=%0d expected cnt=%0d r=%h rd=%0d",
               ovf_cnt, exc_result, exc_rd, expOvf, expExcResult, expExcRd);
    else passCount++;
    out_ready = 1'b1;
    tick();
    checkCount++;
    if (out_result !== 32'h7FFF_FFF0 || out_rd !== 5'd9 || out_we !== 1'b0)
      $display("[TB] FAIL trap_second_head: got r=%h rd=%0d we=%b expected r=7ffffff0 rd=9 we=0",
               out_result, out_rd, out_we);
    else passCount++;
    tick();
  endtask

  task automatic test_unsigned_ovf();
    out_ready = 1'b1;
    // 0xfffffff1 + 0xf wraps to zero; unsigned op so no trap.
    drive(1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkCount++;
    if (out_valid !== 1'b1 || out_we !== 1'b1 || out_zero !== 1'b1 || out_rd !== 5'd4)
      $display("[TB] FAIL unsigned_ovf_head: got v=%b we=%b z=%b rd=%0d expected v=1 we=1 z=1 rd=4",
               out_valid, out_we, out_zero, out_rd);
    else passCount++;
    checkCount++;
    if (ovf_cnt !== expOvf) $display("[TB] FAIL unsigned_ovf_cnt: got %0d expected %0d", ovf_cnt, expOvf);
    else passCount++;
    tick();
  endtask

  task automatic test_exc_clr();
    exc_clr = 1'b1;
    tick();
    exc_clr = 1'b0;
    checkCount++;
    if (exc_valid !== 1'b0) $display("[TB] FAIL exc_clr_alone: got %b expected 0", exc_valid);
    else passCount++;
    out_ready = 1'b1;
    exc_clr = 1'b1;
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1);
    tick();
    exc_clr = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    expOvf = expOvf + 16'd1;
    expExcResult = EXC_ON ? 32'h1234_5678 : 32'd0;
    expExcRd     = EXC_ON ? 5'd5 : 5'd0;
    checkCount++;
    if (exc_valid !== EXC_ON || exc_result !== expExcResult || exc_rd !== expExcRd || ovf_cnt !== expOvf)
      $display("[TB] FAIL exc_clr_with_trap: got v=%b r=%h rd=%0d cnt=%0d expected v=%b r=%h rd=%0d cnt=%0d",
               exc_valid, exc_result, exc_rd, ovf_cnt, EXC_ON, expExcResult, expExcRd, expOvf);
    else passCount++;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_00AA, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
    tick();
    drive(1'b1, 32'h0000_00BB, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
    tick();
    checkCount++;
    if (in_ready !== 1'b0) $display("[TB] FAIL flush_full: got %b expected 0", in_ready);
    else passCount++;
    flush = 1'b1;
    drive(1'b1, 32'h0000_00CC, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_cnt !== expOvf)
      $display("[TB] FAIL flush_full_result: got v=%b rdy=%b cnt=%0d expected v=0 rdy=1 cnt=%0d",
               out_valid, in_ready, ovf_cnt, expOvf);
    else passCount++;
    // With one slot free the trapped push would be accepted, so the flush must drop it.
    drive(1'b1, 32'h0000_00DD, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h0000_00EE, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkCount++;
    if (out_valid !== 1'b0 || ovf_cnt !== expOvf)
      $display("[TB] FAIL flush_drops_push: got v=%b cnt=%0d expected v=0 cnt=%0d",
               out_valid, ovf_cnt, expOvf);
    else passCount++;
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1);
    tick();
    drive(1'b1, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    expOvf = expOvf + 16'd1;
    checkCount++;
    if (in_ready !== 1'b0 || ovf_cnt !== expOvf)
      $display("[TB] FAIL midstall_setup: got rdy=%b cnt=%0d expected rdy=0 cnt=%0d",
               in_ready, ovf_cnt, expOvf);
    else passCount++;
    #2;
    rst = 1'b1;
    #1;
    checkCount++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || in_ready !== 1'b0)
      $display("[TB] FAIL midstall_reset_out: got v=%b r=%h rdy=%b expected v=0 r=0 rdy=0",
               out_valid, out_result, in_ready);
    else passCount++;
    checkCount++;
    if (ovf_cnt !== 16'd0 || exc_valid !== 1'b0 || exc_result !== 32'd0 || exc_rd !== 5'd0)
      $display("[TB] FAIL midstall_reset_state: got cnt=%0d ev=%b er=%h erd=%0d expected all 0",
               ovf_cnt, exc_valid, exc_result, exc_rd);
    else passCount++;
    tick();
    rst = 1'b0;
    #1;
    checkCount++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL midstall_after_reset: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_trap();
    test_unsigned_ovf();
    test_exc_clr();
    test_flush();
    test_reset_midstall();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
